// File: rtl/posit_defines_pkg.sv
// rtl/posit_defines_pkg.sv - shared constants and field record for the posit-to-float path
// Purpose: posit geometry (NBITS, ES), scale/fraction widths, special encodings,
//          and the posit_fields record carried from the field stage to the pack stage.
// Ports:   none (package)
package posit_defines;

  localparam int NBITS   = 32;
  localparam int ES      = 2;
  localparam int SCALE_W = 9;
  localparam int FRAC_W  = 27;
  localparam int RUN_W   = 5;

  localparam logic [NBITS-1:0] POSIT_NAR  = 32'h8000_0000;
  localparam logic [31:0]      FLOAT_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic                      sign;
    logic                      zero;
    logic                      nar;
    logic signed [SCALE_W-1:0] scale;
    logic [FRAC_W-1:0]         frac;
  } posit_fields;

endpackage

// File: rtl/posit_regime_lzc.sv
// rtl/posit_regime_lzc.sv - leading-run counter for the posit regime field
// Purpose: counts how many leading bits of i_bits equal i_bits[30].
// Ports:
//   i_bits  in  31  magnitude bits below the sign
//   o_run   out 5   run length, 1..31
//   o_pol   out 1   polarity of the run (value of i_bits[30])
module posit_regime_lzc
  import posit_defines::*;
(
  input  logic [30:0]      i_bits,
  output logic [RUN_W-1:0] o_run,
  output logic             o_pol
);

  logic [30:0] w_x;
  logic        w_found;

  // Flip to a run of zeros so the first set bit terminates the run; bit 30
  // of w_x is always 0, so the run is never shorter than 1.
  assign w_x   = i_bits ^ {31{i_bits[30]}};
  assign o_pol = i_bits[30];

  always_comb begin
    o_run   = 5'd31;
    w_found = 1'b0;
    for (int i = 30; i >= 0; i--) begin
      if (!w_found && w_x[i]) begin
        o_run   = 5'(30 - i);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/posit_to_float_stream.sv
// rtl/posit_to_float_stream.sv - three-stage streaming posit32 (es=2) to binary32 converter
// Purpose: S1 captures sign/specials/magnitude and regime run, S2 extracts scale
//          and fraction, S3 rounds to nearest-even and packs the float. All stages
//          advance together on a global stall; NaR inputs are counted.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake, in_posit operand
//   out_valid/out_ready   output handshake, out_float result, out_nar NaR flag
//   nar_count, clr_count  saturating NaR counter and its synchronous clear
module posit_to_float_stream
  import posit_defines::*;
#(
  parameter int NBITS = 32,
  parameter int ES    = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_posit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_float,
  output logic             out_nar,
  output logic [CNT_W-1:0] nar_count,
  input  logic             clr_count
);

  logic             w_adv;
  logic             w_accept;
  logic [30:0]      w_mag;
  logic [RUN_W-1:0] w_run;
  logic             w_pol;

  logic             r_s1_valid;
  logic             r_s1_sign;
  logic             r_s1_zero;
  logic             r_s1_nar;
  logic [30:0]      r_s1_mag;
  logic [RUN_W-1:0] r_s1_run;
  logic             r_s1_pol;

  logic             r_s2_valid;
  posit_fields      r_s2_f;
  posit_fields      w_fields;
  logic [5:0]       w_amt;
  logic [8:0]       w_k;
  logic [28:0]      w_rem;

  logic             w_round_up;
  logic [23:0]      w_mant;
  logic [7:0]       w_bexp;
  logic [31:0]      w_float;

  logic             r_out_valid;
  logic [31:0]      r_out_float;
  logic             r_out_nar;
  logic [CNT_W-1:0] r_cnt;

  assign w_adv    = ~r_out_valid | out_ready;
  assign in_ready = w_adv;
  assign w_accept = in_valid & w_adv;

  // Two's-complement negation restricted to the 31 magnitude bits.
  assign w_mag = in_posit[31] ? (~in_posit[30:0] + 31'd1) : in_posit[30:0];

  posit_regime_lzc u_lzc (
    .i_bits (w_mag),
    .o_run  (w_run),
    .o_pol  (w_pol)
  );

  // S2: drop regime plus terminator (run+1 bits); a 31-bit run has no
  // terminator and the shift by 32 leaves nothing, i.e. exp=0 and frac=0.
  assign w_amt = {1'b0, r_s1_run} + 6'd1;
  assign w_rem = 29'((r_s1_mag << w_amt) >> 2);
  assign w_k   = r_s1_pol ? ({4'b0, r_s1_run} - 9'd1) : (9'd0 - {4'b0, r_s1_run});

  always_comb begin
    w_fields       = '0;
    w_fields.sign  = r_s1_sign;
    w_fields.zero  = r_s1_zero;
    w_fields.nar   = r_s1_nar;
    w_fields.scale = (w_k << ES) + 9'(w_rem[28 -: ES]);
    w_fields.frac  = w_rem[FRAC_W-1:0];
  end

  // S3: mantissa carry moves into the exponent; the biased exponent stays
  // within 7..248, so modulo-256 arithmetic is exact.
  assign w_round_up = r_s2_f.frac[3] & ((|r_s2_f.frac[2:0]) | r_s2_f.frac[4]);
  assign w_mant     = {1'b0, r_s2_f.frac[26:4]} + 24'(w_round_up);
  assign w_bexp     = 8'(r_s2_f.scale) + 8'd127 + 8'(w_mant[23]);
  assign w_float    = {r_s2_f.sign, w_bexp, w_mant[22:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_s1_nar    <= 1'b0;
      r_s1_mag    <= '0;
      r_s1_run    <= '0;
      r_s1_pol    <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_f      <= '0;
      r_out_valid <= 1'b0;
      r_out_float <= '0;
      r_out_nar   <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid  <= in_valid;
      r_s1_sign   <= in_posit[31];
      r_s1_zero   <= (in_posit == '0);
      r_s1_nar    <= (in_posit == POSIT_NAR);
      r_s1_mag    <= w_mag;
      r_s1_run    <= w_run;
      r_s1_pol    <= w_pol;
      r_s2_valid  <= r_s1_valid;
      r_s2_f      <= w_fields;
      r_out_valid <= r_s2_valid;
      r_out_nar   <= r_s2_f.nar;
      if (r_s2_f.nar) begin
        r_out_float <= FLOAT_QNAN;
      end else if (r_s2_f.zero) begin
        r_out_float <= 32'h0000_0000;
      end else begin
        r_out_float <= w_float;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_count) begin
      r_cnt <= '0;
    end else if (w_accept && (in_posit == POSIT_NAR) && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_float = r_out_float;
  assign out_nar   = r_out_nar;
  assign nar_count = r_cnt;

endmodule
